multicycle_controller: RTL

//  Parametrised successor to the single-cycle ARM controller: FSM-sequenced control for a

---
 rtl/multicycle_controller_if.sv | 48 ++++
 rtl/multicycle_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Control/status bundle between a multicycle ARM datapath and
//               its controller. The datapath (master) presents instruction
//               fields, ALU flags and memory ready, and the controller
//               (slave) returns the per-cycle control word.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if #(
    parameter int ALUCTRL_W = 4,
    parameter int FLAG_W    = 4
);
    // Instruction fields and status from the datapath
    logic [3:0]           Cond;
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic [FLAG_W-1:0]    ALUFlags;
    logic                 MemReady;

    // Control word back to the datapath
    logic                 PCWrite;
    logic                 IRWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 AdrSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 Illegal;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags, MemReady,
        input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Illegal
    );

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
        output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Illegal
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : FSM-sequenced control for a multicycle ARM datapath sharing
//               one memory and one ALU. Decodes Cond/Op/Funct/Rd, keeps the
//               NZCV flag register, gates writes on the condition and stalls
//               on memory ready.
//               Optional feature macro PERF_CNT_EN adds CycleCnt/RetireCnt.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int ALUCTRL_W = 4,
    parameter int FLAG_W    = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    multicycle_controller_if.slave  bus
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]             CycleCnt,
    output logic [31:0]             RetireCnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] c_alu_add = 2'b00;
    localparam logic [1:0] c_alu_sub = 2'b01;
    localparam logic [1:0] c_alu_and = 2'b10;
    localparam logic [1:0] c_alu_orr = 2'b11;

    // C,V occupy [1:0]; N,Z and any extra MSBs are everything else
    localparam logic [FLAG_W-1:0] c_cv_mask = FLAG_W'(2'b11);
    localparam logic [FLAG_W-1:0] c_nz_mask = ~c_cv_mask;

    state_t            state_q, state_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              condex_q, condex_d;

    logic              w_condex;
    logic [1:0]        w_alu_dp;
    logic              w_is_cmp;
    logic              w_arith;
    logic [1:0]        w_alu_code;
    logic              w_flag_we;
    logic              w_pcwrite, w_irwrite, w_memwrite, w_regwrite, w_illegal;

    // ARM condition table over the stored flags; 1111 never executes
    always_comb begin
        w_condex = 1'b0;
        unique case (bus.Cond)
            4'b0000: w_condex = flags_q[2];
            4'b0001: w_condex = ~flags_q[2];
            4'b0010: w_condex = flags_q[1];
            4'b0011: w_condex = ~flags_q[1];
            4'b0100: w_condex = flags_q[3];
            4'b0101: w_condex = ~flags_q[3];
            4'b0110: w_condex = flags_q[0];
            4'b0111: w_condex = ~flags_q[0];
            4'b1000: w_condex = flags_q[1] & ~flags_q[2];
            4'b1001: w_condex = ~flags_q[1] | flags_q[2];
            4'b1010: w_condex = (flags_q[3] == flags_q[0]);
            4'b1011: w_condex = (flags_q[3] != flags_q[0]);
            4'b1100: w_condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: w_condex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // Data-processing command decode; unknown commands fall back to add
    always_comb begin
        w_alu_dp = c_alu_add;
        w_is_cmp = 1'b0;
        unique case (bus.Funct[4:1])
            4'b0100: w_alu_dp = c_alu_add;
            4'b0010: w_alu_dp = c_alu_sub;
            4'b0000: w_alu_dp = c_alu_and;
            4'b1100: w_alu_dp = c_alu_orr;
            4'b1010: begin
                w_alu_dp = c_alu_sub;
                w_is_cmp = 1'b1;
            end
            default: w_alu_dp = c_alu_add;
        endcase
        w_arith = (w_alu_dp == c_alu_add) || (w_alu_dp == c_alu_sub);
    end

    // Next-state and Moore control decode; strobes held low while in reset
    always_comb begin
        state_d       = state_q;
        condex_d      = condex_q;
        w_pcwrite     = 1'b0;
        w_irwrite     = 1'b0;
        w_memwrite    = 1'b0;
        w_regwrite    = 1'b0;
        w_illegal     = 1'b0;
        w_flag_we     = 1'b0;
        w_alu_code    = c_alu_add;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                w_irwrite     = bus.MemReady;
                w_pcwrite     = bus.MemReady;
                if (bus.MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                unique case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin
                        w_illegal = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcB = 2'b01;
                state_d     = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.AdrSrc = 1'b1;
                if (bus.MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                w_regwrite    = w_condex;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                bus.AdrSrc = 1'b1;
                w_memwrite = w_condex;
                if (bus.MemReady) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                bus.ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                w_alu_code  = w_alu_dp;
                w_flag_we   = bus.Funct[0] & w_condex;
                // Flags may change at this edge; ALUWB must use the
                // condition as judged before the update
                condex_d    = w_condex;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = condex_q & ~w_is_cmp;
                w_pcwrite  = condex_q & (bus.Rd == 4'd15);
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                w_pcwrite     = w_condex;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        bus.PCWrite  = w_pcwrite  & ~reset;
        bus.IRWrite  = w_irwrite  & ~reset;
        bus.MemWrite = w_memwrite & ~reset;
        bus.RegWrite = w_regwrite & ~reset;
        bus.Illegal  = w_illegal  & ~reset;
    end

    // ALU control code in [1:0], upper bits tied low
    always_comb begin
        bus.ALUControl      = '0;
        bus.ALUControl[1:0] = w_alu_code;
    end

    // Instruction-dependent immediate and register-source selects
    always_comb begin
        bus.ImmSrc = (bus.Op == 2'b11) ? 2'b00 : bus.Op;
        bus.RegSrc = {bus.Op == 2'b01, bus.Op == 2'b10};
    end

    // Flag merge: N,Z (and extra MSBs) on any write, C,V only for add/sub
    always_comb begin
        flags_d = flags_q;
        if (w_flag_we) begin
            flags_d = (flags_q & ~c_nz_mask) | (bus.ALUFlags & c_nz_mask);
            if (w_arith) flags_d = (flags_d & ~c_cv_mask) | (bus.ALUFlags & c_cv_mask);
        end
    end

    // State, flag and latched-condition registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            flags_q  <= '0;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] retire_cnt_q;

    // Free-running cycle count and count of returns to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if ((state_q != S_FETCH) && (state_d == S_FETCH))
                retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign CycleCnt  = cycle_cnt_q;
    assign RetireCnt = retire_cnt_q;
`endif

endmodule
`default_nettype wire
